// File: rtl/cdr_pkg.sv
// Shared types and default constants for the CDR phase-interpolator loop controller.
package cdr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2
  } cdr_state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } cdr_dir_e;

  localparam int CODE_W_DEF     = 7;
  localparam int CODE_INIT_DEF  = 0;
  localparam int THRESH_ACQ_DEF = 2;
  localparam int THRESH_TRK_DEF = 8;
  localparam int REV_N_DEF      = 4;
  localparam int LOSS_N_DEF     = 4;

endpackage

// File: rtl/cdr_step_accum.sv
// Signed vote integrator: emits a one-cycle step pulse when the net vote count
// reaches +/-thresh, then restarts from zero.
module cdr_step_accum
  import cdr_pkg::*;
#(
  parameter int ACC_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_step,
  input  logic             clear,
  input  logic             vote_up,
  input  logic             vote_dn,
  input  logic [ACC_W:0]   thresh,
  output logic             hit_up,
  output logic             hit_dn,
  output logic             step_up,
  output logic             step_dn
);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W:0]   acc_ext, acc_nxt, delta, th_s;
  logic                    step_up_q, step_up_d;
  logic                    step_dn_q, step_dn_d;

  always_comb begin
    th_s    = $signed(thresh);
    acc_ext = {acc_q[ACC_W-1], acc_q};
    delta   = '0;
    if (vote_up && !vote_dn) delta = {{ACC_W{1'b0}}, 1'b1};
    if (vote_dn && !vote_up) delta = '1;
    // Sum one bit wider so reaching +T (not representable in ACC_W) is detectable.
    acc_nxt = acc_ext + delta;
    hit_up  = en_step && (acc_nxt == th_s);
    hit_dn  = en_step && (acc_nxt == -th_s);

    acc_d = acc_q;
    if (clear || hit_up || hit_dn) acc_d = '0;
    else if (en_step)              acc_d = acc_nxt[ACC_W-1:0];

    step_up_d = hit_up;
    step_dn_d = hit_dn;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      step_up_q <= 1'b0;
      step_dn_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      step_up_q <= step_up_d;
      step_dn_q <= step_dn_d;
    end
  end

  assign step_up = step_up_q;
  assign step_dn = step_dn_q;

endmodule

// File: rtl/cdr_phase_ctrl.sv
// CDR loop controller: integrates voter decisions, steps the PI code and
// switches between fast-acquire and slow-track gain via a lock FSM.
//
// state   | meaning
// IDLE    | loop disabled, accumulator held at 0, code held
// ACQUIRE | fast gain (THRESH_ACQ), waiting for REV_N consecutive reversals
// TRACK   | slow gain (THRESH_TRK), locked; LOSS_N same-direction steps drop lock
module cdr_phase_ctrl
  import cdr_pkg::*;
#(
  parameter int CODE_W     = CODE_W_DEF,
  parameter int CODE_INIT  = CODE_INIT_DEF,
  parameter int THRESH_ACQ = THRESH_ACQ_DEF,
  parameter int THRESH_TRK = THRESH_TRK_DEF,
  parameter int REV_N      = REV_N_DEF,
  parameter int LOSS_N     = LOSS_N_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              vote_up,
  input  logic              vote_dn,
  output logic [CODE_W-1:0] pi_code,
  output logic              step_up,
  output logic              step_dn,
  output logic              locked
);

  localparam int ACC_W = $clog2(THRESH_TRK) + 1;
  localparam int MAX_N = (REV_N > LOSS_N) ? REV_N : LOSS_N;
  localparam int CNT_W = $clog2(MAX_N + 1);

  localparam logic [CNT_W-1:0] REV_LIM  = CNT_W'(REV_N);
  localparam logic [CNT_W-1:0] LOSS_LIM = CNT_W'(LOSS_N);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [ACC_W:0]   TH_ACQ   = (ACC_W+1)'(THRESH_ACQ);
  localparam logic [ACC_W:0]   TH_TRK   = (ACC_W+1)'(THRESH_TRK);

  cdr_state_e        state_q, state_d;
  cdr_dir_e          last_q, last_d, step_dir;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CNT_W-1:0]  rev_q, rev_d;
  logic [CNT_W-1:0]  run_q, run_d;
  logic              locked_q, locked_d;
  logic              en_step, acc_clr, hit_up, hit_dn;
  logic [ACC_W:0]    thresh;

  assign en_step = en && (state_q != IDLE);
  assign thresh  = (state_q == TRACK) ? TH_TRK : TH_ACQ;

  cdr_step_accum #(.ACC_W(ACC_W)) u_accum (
    .clk     (clk),
    .rst     (rst),
    .en_step (en_step),
    .clear   (acc_clr),
    .vote_up (vote_up),
    .vote_dn (vote_dn),
    .thresh  (thresh),
    .hit_up  (hit_up),
    .hit_dn  (hit_dn),
    .step_up (step_up),
    .step_dn (step_dn)
  );

  always_comb begin
    state_d  = state_q;
    locked_d = locked_q;
    last_d   = last_q;
    code_d   = code_q;
    rev_d    = rev_q;
    run_d    = run_q;
    step_dir = DIR_NONE;

    if (hit_up)      code_d = code_q + 1'b1;
    else if (hit_dn) code_d = code_q - 1'b1;

    if (hit_up || hit_dn) begin
      step_dir = hit_up ? DIR_UP : DIR_DN;
      if (last_q == DIR_NONE) begin
        run_d = CNT_ONE;
      end else if (step_dir != last_q) begin
        rev_d = (rev_q == '1) ? rev_q : rev_q + 1'b1;
        run_d = CNT_ONE;
      end else begin
        rev_d = '0;
        run_d = (run_q == '1) ? run_q : run_q + 1'b1;
      end
      last_d = step_dir;
    end

    case (state_q)
      IDLE:    if (en) state_d = ACQUIRE;
      ACQUIRE: if (rev_d >= REV_LIM) begin
                 state_d  = TRACK;
                 locked_d = 1'b1;
               end
      TRACK:   if (run_d >= LOSS_LIM) begin
                 state_d  = ACQUIRE;
                 locked_d = 1'b0;
               end
      default: state_d = IDLE;
    endcase

    if (!en) begin
      state_d  = IDLE;
      locked_d = 1'b0;
    end

    // Last direction survives ACQUIRE<->TRACK; only IDLE forgets it.
    if (state_d != state_q) begin
      rev_d = '0;
      run_d = '0;
    end
    if (state_d == IDLE) last_d = DIR_NONE;

    acc_clr = (state_d != state_q) || (state_q == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= DIR_NONE;
      code_q   <= CODE_W'(CODE_INIT);
      rev_q    <= '0;
      run_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      code_q   <= code_d;
      rev_q    <= rev_d;
      run_q    <= run_d;
      locked_q <= locked_d;
    end
  end

  assign pi_code = code_q;
  assign locked  = locked_q;

endmodule
